// File: rtl/crg_clk_ctrl.sv
// Enable/select sequencer in front of the CRG: turns per-domain requests and activity into
// hysteresis-filtered clock enables, settled-clock acks and a glitch-safe source select.
module crg_clk_ctrl #(
  parameter int unsigned        NUM_DOM    = 4,
  parameter int unsigned        SEL_DOM    = 1,
  parameter int unsigned        IDLE_CYC   = 16,
  parameter int unsigned        SETTLE_CYC = 4,
  parameter logic [NUM_DOM-1:0] RST_ON     = NUM_DOM'(4'b0001)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_DOM-1:0] req,
  input  logic [NUM_DOM-1:0] busy,
  input  logic               force_on,
  input  logic               sel_req,
  output logic [NUM_DOM-1:0] clk_en,
  output logic               clk_sel,
  output logic [NUM_DOM-1:0] ack,
  output logic               sel_done
);

  typedef enum logic [2:0] {
    StOff,
    StWake,
    StOn,
    StIdleWait,
    StSleep,
    StSwOff,
    StSw,
    StSwOn
  } dom_st_e;

  localparam logic [7:0] SettleLast = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] IdleLast   = 8'(IDLE_CYC - 1);

  logic boot_q;
  logic sel_off;
  logic sel_sw;

  // High only for the first cycle after reset release, so RST_ON domains wake unconditionally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      boot_q <= 1'b1;
    end else begin
      boot_q <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_DOM; i++) begin : g_dom
    localparam bit IsSel = (i == SEL_DOM);

    dom_st_e    st_q;
    logic [7:0] cnt_q;
    logic       en_q;
    logic       ack_q;
    logic       wake;
    logic       idle;
    logic       sw_pend;

    assign wake    = req[i] | force_on | (boot_q & RST_ON[i]);
    assign idle    = ~req[i] & ~busy[i] & ~force_on;
    assign sw_pend = IsSel && (sel_req != clk_sel);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st_q  <= StOff;
        cnt_q <= '0;
        en_q  <= 1'b0;
        ack_q <= 1'b0;
      end else begin
        case (st_q)
          StOff: begin
            cnt_q <= '0;
            if (wake) begin
              st_q <= StWake;
              en_q <= 1'b1;
            end
          end
          StWake: begin
            if (cnt_q == SettleLast) begin
              st_q  <= StOn;
              cnt_q <= '0;
              ack_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          StOn: begin
            cnt_q <= '0;
            if (sw_pend) begin
              st_q  <= StSwOff;
              en_q  <= 1'b0;
              ack_q <= 1'b0;
            end else if (idle) begin
              st_q <= StIdleWait;
            end
          end
          StIdleWait: begin
            if (sw_pend) begin
              st_q  <= StSwOff;
              cnt_q <= '0;
              en_q  <= 1'b0;
              ack_q <= 1'b0;
            end else if (!idle) begin
              // Any activity restarts the idle hysteresis from zero.
              st_q  <= StOn;
              cnt_q <= '0;
            end else if (cnt_q == IdleLast) begin
              st_q  <= StSleep;
              cnt_q <= '0;
              en_q  <= 1'b0;
              ack_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          StSleep: begin
            // Wake requests are held until OFF; a sleep always runs to completion.
            if (cnt_q == SettleLast) begin
              st_q  <= StOff;
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          StSwOff: begin
            if (cnt_q == SettleLast) begin
              st_q  <= StSw;
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          StSw: begin
            st_q  <= StSwOn;
            cnt_q <= '0;
            en_q  <= 1'b1;
          end
          StSwOn: begin
            if (cnt_q == SettleLast) begin
              st_q  <= StOn;
              cnt_q <= '0;
              ack_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          default: begin
            st_q  <= StOff;
            cnt_q <= '0;
            en_q  <= 1'b0;
            ack_q <= 1'b0;
          end
        endcase
      end
    end

    assign clk_en[i] = en_q;
    assign ack[i]    = ack_q;

    if (IsSel) begin : g_sel
      assign sel_off = (st_q == StOff);
      // Last settle cycle with the enable low: the select may move on this edge.
      assign sel_sw  = (st_q == StSwOff) && (cnt_q == SettleLast);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sel  <= 1'b0;
      sel_done <= 1'b0;
    end else begin
      sel_done <= 1'b0;
      if ((sel_off || sel_sw) && (sel_req != clk_sel)) begin
        clk_sel  <= sel_req;
        sel_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_crg_clk_ctrl.sv
// Directed bench for crg_clk_ctrl with default parameters (SETTLE_CYC=4, IDLE_CYC=16).
// Inputs change and outputs are sampled on the falling edge.
module tb_crg_clk_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] busy;
  logic       force_on;
  logic       sel_req;
  logic [3:0] clk_en;
  logic       clk_sel;
  logic [3:0] ack;
  logic       sel_done;

  int n_cmp = 0;
  int n_err = 0;

  logic mon_on   = 1'b0;
  logic prev_en1 = 1'b0;
  logic prev_sel = 1'b0;

  crg_clk_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .busy     (busy),
    .force_on (force_on),
    .sel_req  (sel_req),
    .clk_en   (clk_en),
    .clk_sel  (clk_sel),
    .ack      (ack),
    .sel_done (sel_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Cycle-by-cycle invariants, sampled just after each active edge.
  always @(posedge clk) begin
    #2;
    if (mon_on && rst_n) begin
      check("ack_implies_en", 32'(ack & ~clk_en), 32'd0);
      if (prev_en1 === 1'b1) check("sel_stable_while_en", 32'(clk_sel), 32'(prev_sel));
    end
    prev_en1 = clk_en[1];
    prev_sel = clk_sel;
  end

  initial begin
    rst_n = 1'b0; req = '0; busy = '0; force_on = 1'b0; sel_req = 1'b0;
    step(2);
    check("rst_clk_en", 32'(clk_en), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_clk_sel", 32'(clk_sel), 32'h0);
    check("rst_sel_done", 32'(sel_done), 32'h0);
    mon_on = 1'b1;

    // Reset release: domain 0 wakes without a request.
    rst_n = 1'b1;
    step(1);
    check("boot_en", 32'(clk_en), 32'h1);
    check("boot_ack", 32'(ack), 32'h0);
    step(3);
    check("boot_ack_early", 32'(ack), 32'h0);
    step(1);
    check("boot_ack", 32'(ack), 32'h1);
    check("boot_en_others", 32'(clk_en[3:1]), 32'h0);
    busy[0] = 1'b1;

    // Domain 2: one-cycle request, settle, idle out, sleep not aborted by a new request.
    req[2] = 1'b1;
    step(1);
    check("d2_en_rise", 32'(clk_en[2]), 32'h1);
    check("d2_ack_wake", 32'(ack[2]), 32'h0);
    req[2] = 1'b0;
    step(3);
    check("d2_ack_pre", 32'(ack[2]), 32'h0);
    step(1);
    check("d2_ack", 32'(ack[2]), 32'h1);
    step(16);
    check("d2_en_idle_last", 32'(clk_en[2]), 32'h1);
    step(1);
    check("d2_en_gated", 32'(clk_en[2]), 32'h0);
    check("d2_ack_gated", 32'(ack[2]), 32'h0);
    req[2] = 1'b1;
    step(4);
    check("d2_sleep_held", 32'(clk_en[2]), 32'h0);
    step(1);
    check("d2_rewake", 32'(clk_en[2]), 32'h1);
    req[2] = 1'b0;

    // Domain 3: activity at idle count 15 restarts the hysteresis.
    req[3] = 1'b1;
    step(1);
    req[3] = 1'b0;
    step(4);
    check("d3_ack", 32'(ack[3]), 32'h1);
    step(16);
    check("d3_en_cnt15", 32'(clk_en[3]), 32'h1);
    busy[3] = 1'b1;
    step(1);
    check("d3_en_kept", 32'(clk_en[3]), 32'h1);
    check("d3_ack_kept", 32'(ack[3]), 32'h1);
    busy[3] = 1'b0;
    step(16);
    check("d3_en_restart", 32'(clk_en[3]), 32'h1);
    step(1);
    check("d3_en_gated", 32'(clk_en[3]), 32'h0);

    // Domain 1 ON: select change sequences the enable around the switch.
    req[1] = 1'b1;
    step(1);
    check("d1_en_rise", 32'(clk_en[1]), 32'h1);
    step(4);
    check("d1_ack", 32'(ack[1]), 32'h1);
    sel_req = 1'b1;
    step(1);
    check("sw_en_off", 32'(clk_en[1]), 32'h0);
    check("sw_ack_off", 32'(ack[1]), 32'h0);
    check("sw_sel_held", 32'(clk_sel), 32'h0);
    step(3);
    check("sw_en_off_last", 32'(clk_en[1]), 32'h0);
    check("sw_sel_held_last", 32'(clk_sel), 32'h0);
    check("sw_done_pre", 32'(sel_done), 32'h0);
    step(1);
    check("sw_sel", 32'(clk_sel), 32'h1);
    check("sw_done", 32'(sel_done), 32'h1);
    check("sw_en_at_sw", 32'(clk_en[1]), 32'h0);
    step(1);
    check("sw_en_on", 32'(clk_en[1]), 32'h1);
    check("sw_done_single", 32'(sel_done), 32'h0);
    check("sw_ack_pre", 32'(ack[1]), 32'h0);
    step(3);
    check("sw_ack_settle", 32'(ack[1]), 32'h0);
    step(1);
    check("sw_ack", 32'(ack[1]), 32'h1);

    // Domain 1 OFF: select follows on the next edge, enable stays low.
    req[1] = 1'b0;
    step(21);
    check("off_en", 32'(clk_en[1]), 32'h0);
    check("off_sel_before", 32'(clk_sel), 32'h1);
    sel_req = 1'b0;
    step(1);
    check("off_sel", 32'(clk_sel), 32'h0);
    check("off_done", 32'(sel_done), 32'h1);
    check("off_en_low", 32'(clk_en[1]), 32'h0);
    step(1);
    check("off_done_single", 32'(sel_done), 32'h0);
    check("off_en_still_low", 32'(clk_en[1]), 32'h0);

    // Domain 1 ON: select request withdrawn mid-sequence, enable still re-sequences.
    req[1] = 1'b1;
    step(5);
    check("tb_ack", 32'(ack[1]), 32'h1);
    sel_req = 1'b1;
    step(1);
    check("tb_en_off", 32'(clk_en[1]), 32'h0);
    sel_req = 1'b0;
    step(4);
    check("tb_sel_kept", 32'(clk_sel), 32'h0);
    check("tb_no_done", 32'(sel_done), 32'h0);
    check("tb_en_sw", 32'(clk_en[1]), 32'h0);
    step(1);
    check("tb_en_back", 32'(clk_en[1]), 32'h1);
    step(4);
    check("tb_ack_back", 32'(ack[1]), 32'h1);
    req[1] = 1'b0;

    // force_on: everything comes up and is never gated.
    force_on = 1'b1;
    busy = '0;
    step(20);
    check("force_en", 32'(clk_en), 32'hf);
    check("force_ack", 32'(ack), 32'hf);
    for (int i = 0; i < 100; i++) begin
      step(1);
      check("force_hold", 32'(ack), 32'hf);
    end

    // force_on does not block select sequencing; reset wins mid-switch.
    sel_req = 1'b1;
    step(5);
    check("force_sw_sel", 32'(clk_sel), 32'h1);
    check("force_sw_done", 32'(sel_done), 32'h1);
    rst_n = 1'b0;
    step(1);
    check("rst_mid_en", 32'(clk_en), 32'h0);
    check("rst_mid_ack", 32'(ack), 32'h0);
    check("rst_mid_sel", 32'(clk_sel), 32'h0);
    check("rst_mid_done", 32'(sel_done), 32'h0);

    // Reset while domain 2 is waking.
    force_on = 1'b0;
    sel_req = 1'b0;
    req = 4'b0100;
    rst_n = 1'b1;
    step(1);
    check("wake2_en", 32'(clk_en), 32'h5);
    check("wake2_ack", 32'(ack), 32'h0);
    rst_n = 1'b0;
    step(1);
    check("rst_wake_en", 32'(clk_en), 32'h0);
    check("rst_wake_ack", 32'(ack), 32'h0);
    check("rst_wake_sel", 32'(clk_sel), 32'h0);
    check("rst_wake_done", 32'(sel_done), 32'h0);
    rst_n = 1'b1;
    req = '0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
